fetch_ctrl: RTL and testbench

Program-counter owner and instruction-fetch sequencer that drives the select side of `pc_mux` and consumes its result. It holds the PC register and produces `io_pc`, `io_pc_4` and `io_pc_sel` for the mux. It reloads the PC from the mux output `io_to_pc` every cycle. It issues one instruction-memory request at a time and buffers the returned instruction, with its PC, toward decode through a valid/ready handshake.

---
 rtl/fetch_ctrl.sv | 147 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: owns the program counter, drives the pc_mux select and
// sequences single-outstanding instruction fetches into a one-entry
// output buffer toward decode.
//
// state   | meaning
// --------+--------------------------------------------------------
// ST_BOOT | first cycle after reset, PC held, no request
// ST_REQ  | request may issue to imem
// ST_WAIT | one request outstanding, waiting for its response
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] io_to_pc,
    output logic [31:0] io_pc,
    output logic [31:0] io_pc_4,
    output logic [3:0]  io_pc_sel,
    input  logic        io_jmp_br_valid,
    input  logic        io_stall,
    output logic        io_imem_req_valid,
    input  logic        io_imem_req_ready,
    output logic [31:0] io_imem_req_addr,
    input  logic        io_imem_resp_valid,
    input  logic [31:0] io_imem_resp_data,
    output logic        io_inst_valid,
    input  logic        io_inst_ready,
    output logic [31:0] io_inst,
    output logic [31:0] io_inst_pc,
    output logic        io_misaligned
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        misaligned_q, misaligned_d;

    logic        redirect;
    logic        capture;
    logic        req_valid;
    logic [3:0]  pc_sel;

    // State and datapath registers; everything returns to reset values at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_PC;
            kill_q       <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= 32'h0;
            inst_pc_q    <= 32'h0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            kill_q       <= kill_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Next-state, mux select, request handshake and buffer update.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        kill_d       = kill_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        misaligned_d = 1'b0;
        req_valid    = 1'b0;
        pc_sel       = 4'd1;

        // A redirect outranks a capture: a response that lands together
        // with a redirect belongs to the old path and is dropped.
        redirect = io_jmp_br_valid && (state_q != ST_BOOT);
        capture  = (state_q == ST_WAIT) && io_imem_resp_valid && !kill_q && !redirect;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                req_valid = !io_stall && (!inst_valid_q || io_inst_ready);
                if (req_valid && io_imem_req_ready) begin
                    state_d = ST_WAIT;
                    kill_d  = redirect;
                end
            end
            ST_WAIT: begin
                if (io_imem_resp_valid) begin
                    state_d = ST_REQ;
                    kill_d  = 1'b0;
                end else if (redirect) begin
                    kill_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        if (state_q == ST_BOOT) begin
            pc_sel = 4'd1;
        end else if (redirect) begin
            pc_sel = 4'd2;
        end else if (capture) begin
            pc_sel = 4'd0;
        end

        if (state_q != ST_BOOT) begin
            pc_d = redirect ? {io_to_pc[31:2], 2'b00} : io_to_pc;
        end

        if (capture) begin
            inst_valid_d = 1'b1;
            inst_d       = io_imem_resp_data;
            inst_pc_d    = pc_q;
        end else if (redirect || io_inst_ready) begin
            inst_valid_d = 1'b0;
        end

        misaligned_d = redirect && (io_to_pc[1:0] != 2'b00);
    end

    assign io_pc             = pc_q;
    assign io_pc_4           = pc_q + 32'd4;
    assign io_pc_sel         = pc_sel;
    assign io_imem_req_valid = req_valid;
    assign io_imem_req_addr  = pc_q;
    assign io_inst_valid     = inst_valid_q;
    assign io_inst           = inst_q;
    assign io_inst_pc        = inst_pc_q;
    assign io_misaligned     = misaligned_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector tables for the fetch scenarios,
// a mid-WAIT async reset sequence, and a randomized run against a
// transaction-level model of the fetch unit.
module tb_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] io_to_pc;
    logic [31:0] io_pc, io_pc_4;
    logic [3:0]  io_pc_sel;
    logic        io_jmp_br_valid = 1'b0;
    logic        io_stall = 1'b0;
    logic        io_imem_req_valid;
    logic        io_imem_req_ready = 1'b0;
    logic [31:0] io_imem_req_addr;
    logic        io_imem_resp_valid = 1'b0;
    logic [31:0] io_imem_resp_data = 32'h0;
    logic        io_inst_valid;
    logic        io_inst_ready = 1'b0;
    logic [31:0] io_inst, io_inst_pc;
    logic        io_misaligned;
    logic [31:0] jmp_tgt = 32'h0;

    int n_pass = 0;
    int n_total = 0;

    fetch_ctrl #(.RESET_PC(RST_PC)) dut (
        .clock              (clock),
        .reset              (reset),
        .io_to_pc           (io_to_pc),
        .io_pc              (io_pc),
        .io_pc_4            (io_pc_4),
        .io_pc_sel          (io_pc_sel),
        .io_jmp_br_valid    (io_jmp_br_valid),
        .io_stall           (io_stall),
        .io_imem_req_valid  (io_imem_req_valid),
        .io_imem_req_ready  (io_imem_req_ready),
        .io_imem_req_addr   (io_imem_req_addr),
        .io_imem_resp_valid (io_imem_resp_valid),
        .io_imem_resp_data  (io_imem_resp_data),
        .io_inst_valid      (io_inst_valid),
        .io_inst_ready      (io_inst_ready),
        .io_inst            (io_inst),
        .io_inst_pc         (io_inst_pc),
        .io_misaligned      (io_misaligned)
    );

    always #5 clock = ~clock;

    // External pc_mux
    always_comb begin
        case (io_pc_sel)
            4'd0:    io_to_pc = io_pc_4;
            4'd1:    io_to_pc = io_pc;
            4'd2:    io_to_pc = jmp_tgt;
            default: io_to_pc = io_pc_4;
        endcase
    end

    typedef struct {
        logic        rr, rsp, ir, st, jmp;
        logic [31:0] rdata, tgt;
        logic [31:0] pc;
        logic [3:0]  sel;
        logic        rv, iv;
        logic [31:0] inst, ipc;
        logic        mis;
    } vec_t;

    vec_t tbl1[$];
    vec_t tbl2[$];

    function automatic vec_t mk(logic rr, logic rsp, logic ir, logic st, logic jmp,
                                logic [31:0] rdata, logic [31:0] tgt,
                                logic [31:0] pc, logic [3:0] sel, logic rv, logic iv,
                                logic [31:0] inst, logic [31:0] ipc, logic mis);
        vec_t v;
        v.rr = rr; v.rsp = rsp; v.ir = ir; v.st = st; v.jmp = jmp;
        v.rdata = rdata; v.tgt = tgt;
        v.pc = pc; v.sel = sel; v.rv = rv; v.iv = iv;
        v.inst = inst; v.ipc = ipc; v.mis = mis;
        return v;
    endfunction

    task automatic drive(input logic rr, input logic rsp, input logic ir, input logic st,
                         input logic jmp, input logic [31:0] rdata, input logic [31:0] tgt);
        io_imem_req_ready  = rr;
        io_imem_resp_valid = rsp;
        io_inst_ready      = ir;
        io_stall           = st;
        io_jmp_br_valid    = jmp;
        io_imem_resp_data  = rdata;
        jmp_tgt            = tgt;
    endtask

    task automatic check_outs(input string name, input logic [31:0] pc, input logic [3:0] sel,
                              input logic rv, input logic iv, input logic [31:0] inst,
                              input logic [31:0] ipc, input logic mis);
        n_total++;
        if (io_pc === pc && io_pc_4 === pc + 32'd4 && io_pc_sel === sel &&
            io_imem_req_valid === rv && io_imem_req_addr === pc &&
            io_inst_valid === iv && io_inst === inst && io_inst_pc === ipc &&
            io_misaligned === mis) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got pc=%h pc4=%h sel=%0d rv=%b addr=%h iv=%b inst=%h ipc=%h mis=%b; want pc=%h sel=%0d rv=%b iv=%b inst=%h ipc=%h mis=%b",
                     name, io_pc, io_pc_4, io_pc_sel, io_imem_req_valid, io_imem_req_addr,
                     io_inst_valid, io_inst, io_inst_pc, io_misaligned,
                     pc, sel, rv, iv, inst, ipc, mis);
        end
    endtask

    // Called right after a falling edge; leaves the bench at the next falling edge.
    task automatic run_vec(input string tag, input int idx, input vec_t v);
        drive(v.rr, v.rsp, v.ir, v.st, v.jmp, v.rdata, v.tgt);
        #1;
        check_outs($sformatf("%s[%0d]", tag, idx), v.pc, v.sel, v.rv, v.iv, v.inst, v.ipc, v.mis);
        @(negedge clock);
    endtask

    // Transaction-level reference model
    logic        m_boot, m_out, m_stale, m_bv, m_mis;
    logic [31:0] m_pc, m_binst, m_bpc;

    task automatic model_reset();
        m_boot = 1'b1; m_out = 1'b0; m_stale = 1'b0; m_bv = 1'b0; m_mis = 1'b0;
        m_pc = RST_PC; m_binst = 32'h0; m_bpc = 32'h0;
    endtask

    initial begin
        logic [31:0] i13, ia;
        i13 = 32'h0000_0013;
        ia  = 32'h0010_0093;

        // boot, first fetch, backpressure, redirect in WAIT, misaligned, stall
        tbl1.push_back(mk(1,0,1,0,0, 0,0,              RST_PC,       1,0,0, 0,0,0));
        tbl1.push_back(mk(1,0,1,0,0, 0,0,              RST_PC,       1,1,0, 0,0,0));
        tbl1.push_back(mk(1,1,1,0,0, i13,0,            RST_PC,       0,0,0, 0,0,0));
        tbl1.push_back(mk(1,0,0,0,0, 0,0,              32'h80000004, 1,0,1, i13,RST_PC,0));
        tbl1.push_back(mk(1,0,0,0,0, 0,0,              32'h80000004, 1,0,1, i13,RST_PC,0));
        tbl1.push_back(mk(1,0,0,0,0, 0,0,              32'h80000004, 1,0,1, i13,RST_PC,0));
        tbl1.push_back(mk(1,0,1,0,0, 0,0,              32'h80000004, 1,1,1, i13,RST_PC,0));
        tbl1.push_back(mk(0,0,1,0,1, 0,32'h80000100,   32'h80000004, 2,0,0, i13,RST_PC,0));
        tbl1.push_back(mk(0,1,1,0,0, 32'hDEADBEEF,0,   32'h80000100, 1,0,0, i13,RST_PC,0));
        tbl1.push_back(mk(1,0,1,0,0, 0,0,              32'h80000100, 1,1,0, i13,RST_PC,0));
        tbl1.push_back(mk(0,1,1,0,0, ia,0,             32'h80000100, 0,0,0, i13,RST_PC,0));
        tbl1.push_back(mk(0,0,1,0,0, 0,0,              32'h80000104, 1,1,1, ia,32'h80000100,0));
        tbl1.push_back(mk(0,0,1,0,1, 0,32'h80000102,   32'h80000104, 2,1,0, ia,32'h80000100,0));
        tbl1.push_back(mk(0,0,1,1,0, 0,0,              32'h80000100, 1,0,0, ia,32'h80000100,1));
        tbl1.push_back(mk(1,0,1,1,0, 0,0,              32'h80000100, 1,0,0, ia,32'h80000100,0));
        tbl1.push_back(mk(1,0,1,1,1, 0,32'h80000200,   32'h80000100, 2,0,0, ia,32'h80000100,0));
        tbl1.push_back(mk(1,0,1,0,0, 0,0,              32'h80000200, 1,1,0, ia,32'h80000100,0));
        tbl1.push_back(mk(0,0,1,0,0, 0,0,              32'h80000200, 1,0,0, ia,32'h80000100,0));

        // after async reset: late responses ignored, then PC wrap
        tbl2.push_back(mk(0,1,1,0,0, 32'h55,0,         RST_PC,       1,0,0, 0,0,0));
        tbl2.push_back(mk(0,1,1,0,0, 32'h55,0,         RST_PC,       1,1,0, 0,0,0));
        tbl2.push_back(mk(0,1,1,0,0, 32'h55,0,         RST_PC,       1,1,0, 0,0,0));
        tbl2.push_back(mk(0,0,1,0,1, 0,32'hFFFFFFFC,   RST_PC,       2,1,0, 0,0,0));
        tbl2.push_back(mk(1,0,1,0,0, 0,0,              32'hFFFFFFFC, 1,1,0, 0,0,0));
        tbl2.push_back(mk(0,1,1,0,0, 32'hAA,0,         32'hFFFFFFFC, 0,0,0, 0,0,0));
        tbl2.push_back(mk(0,0,1,0,0, 0,0,              32'h00000000, 1,1,1, 32'hAA,32'hFFFFFFFC,0));

        // reset values
        drive(0,0,0,0,0,0,0);
        repeat (2) @(negedge clock);
        check_outs("reset_values", RST_PC, 4'd1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        reset = 1'b1;

        foreach (tbl1[i]) run_vec("seq", i, tbl1[i]);

        // asynchronous reset in the middle of WAIT
        drive(0,0,0,0,0,0,0);
        #2 reset = 1'b0;
        #1 check_outs("async_reset", RST_PC, 4'd1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        foreach (tbl2[i]) run_vec("post_reset", i, tbl2[i]);

        // randomized run against the reference model
        drive(0,0,0,0,0,0,0);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic        e_rv, e_cap, acc;
            logic [3:0]  e_sel;
            logic        r_rr, r_rsp, r_ir, r_st, r_jmp;
            logic [31:0] r_data, r_tgt;
            r_rr   = ($urandom_range(0, 9) < 7);
            r_ir   = ($urandom_range(0, 9) < 7);
            r_st   = ($urandom_range(0, 4) == 0);
            r_jmp  = ($urandom_range(0, 9) == 0);
            r_rsp  = m_out ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
            r_data = $urandom;
            r_tgt  = $urandom;
            drive(r_rr, r_rsp, r_ir, r_st, r_jmp, r_data, r_tgt);

            e_cap = !m_boot && !r_jmp && m_out && r_rsp && !m_stale;
            e_rv  = !m_boot && !m_out && !r_st && (!m_bv || r_ir);
            if (m_boot)      e_sel = 4'd1;
            else if (r_jmp)  e_sel = 4'd2;
            else if (e_cap)  e_sel = 4'd0;
            else             e_sel = 4'd1;

            #1;
            check_outs($sformatf("rand[%0d]", c), m_pc, e_sel, e_rv, m_bv, m_binst, m_bpc, m_mis);

            @(posedge clock);
            acc   = e_rv && r_rr;
            m_mis = !m_boot && r_jmp && (r_tgt[1:0] != 2'b00);
            if (e_cap) begin
                m_bv = 1'b1; m_binst = r_data; m_bpc = m_pc;
            end else if ((!m_boot && r_jmp) || r_ir) begin
                m_bv = 1'b0;
            end
            if (!m_boot) begin
                if (!m_out) begin
                    m_out   = acc;
                    m_stale = acc && r_jmp;
                end else if (r_rsp) begin
                    m_out   = 1'b0;
                    m_stale = 1'b0;
                end else if (r_jmp) begin
                    m_stale = 1'b1;
                end
                if (r_jmp)      m_pc = r_tgt & 32'hFFFF_FFFC;
                else if (e_cap) m_pc = m_pc + 32'd4;
            end
            m_boot = 1'b0;
            @(negedge clock);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
